// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and framing widths.
package uart_pkg;

    localparam int UART_MAX_BITS = 8;
    localparam int BIT_CNT_W     = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive framing engine: start detect, mid-bit sampling, parity and stop checks.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on the synchronised line
// START  | baud counter running, confirming the start bit at mid-bit
// DATA   | shifting in DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit and latching the mismatch flag
// STOP   | sampling the stop bit and issuing the result strobe
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       baud_pulse,
    output logic       baud_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    import uart_pkg::*;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    uart_state_e            state, state_nxt;
    logic                   rxd_s, rxd_d;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   par_err_q;
    logic                   par_bad;
    logic                   shift_en, cnt_clr, par_store, data_load;
    logic                   valid_nxt, ferr_nxt, perr_nxt;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Parity over data plus the received parity bit: 1 means odd count of ones.
    assign par_bad = (PARITY_ODD != 0) ? ~(^shift_reg ^ rxd_s) : (^shift_reg ^ rxd_s);

    assign baud_en = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        par_store = 1'b0;
        data_load = 1'b0;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (rxd_d && !rxd_s) state_nxt = START;
            end
            START: begin
                if (baud_pulse) begin
                    if (!rxd_s) begin
                        state_nxt = DATA;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_pulse) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        if (PARITY_EN != 0) state_nxt = PARITY;
                        else                state_nxt = STOP;
                    end
                end
            end
            PARITY: begin
                if (baud_pulse) begin
                    par_store = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_pulse) begin
                    data_load = 1'b1;
                    if (rxd_s) begin
                        valid_nxt = !par_err_q;
                        perr_nxt  = par_err_q;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rxd_d      <= 1'b1;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_err_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            rxd_d      <= rxd_s;
            rx_valid   <= valid_nxt;
            frame_err  <= ferr_nxt;
            parity_err <= perr_nxt;
            if (cnt_clr) begin
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en)  shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
            if (par_store) par_err_q <= par_bad;
            if (data_load) rx_data   <= UART_MAX_BITS'(shift_reg);
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: 8N1, 8E1 and 5N1 instances fed by a baud_gen model.
module tb_uart_rx_fsm;

    localparam int BPS = 434;
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;
    logic [2:0] baud_pulse;
    logic [2:0] baud_en;
    logic [2:0] rx_valid, frame_err, parity_err, busy;
    logic [7:0] rx_data [3];
    int         bcnt [3];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #10 clk = ~clk;

    // baud_gen model: counter held at 0 while disabled, pulse at mid-bit then every BPS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                bcnt[i]       <= 0;
                baud_pulse[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!baud_en[i]) begin
                    bcnt[i]       <= 0;
                    baud_pulse[i] <= 1'b0;
                end else begin
                    bcnt[i]       <= (bcnt[i] == BPS - 1) ? 0 : bcnt[i] + 1;
                    baud_pulse[i] <= (bcnt[i] == BPS / 2);
                end
            end
        end
    end

    uart_rx_fsm #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut8 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .baud_pulse(baud_pulse[0]),
        .baud_en(baud_en[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .busy(busy[0])
    );

    uart_rx_fsm #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .baud_pulse(baud_pulse[1]),
        .baud_en(baud_en[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .busy(busy[1])
    );

    uart_rx_fsm #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) dut5 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .baud_pulse(baud_pulse[2]),
        .baud_en(baud_en[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .frame_err(frame_err[2]), .parity_err(parity_err[2]), .busy(busy[2])
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_strobe(input int d, input int kind, input logic [7:0] data);
        exp_t e;
        e.dut  = d;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int d, input logic [7:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input logic stop_bit);
        rxd[d] = 1'b0;
        wait_cycles(BPS);
        for (int i = 0; i < nbits; i++) begin
            rxd[d] = data[i];
            wait_cycles(BPS);
        end
        if (has_par) begin
            rxd[d] = par_bit;
            wait_cycles(BPS);
        end
        rxd[d] = stop_bit;
        wait_cycles(BPS);
    endtask

    // Monitor: every output strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && (rx_valid[i] || frame_err[i] || parity_err[i])) begin
                int   kind;
                exp_t e;
                kind = rx_valid[i] ? K_VALID : (frame_err[i] ? K_FERR : K_PERR);
                check($sformatf("strobe_onehot_dut%0d", i),
                      $countones({rx_valid[i], frame_err[i], parity_err[i]}), 1);
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_strobe_dut%0d_kind%0d", i, kind), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_dut", i, e.dut);
                    check($sformatf("strobe_kind_dut%0d", i), kind, e.kind);
                    check($sformatf("rx_data_dut%0d", i), int'(rx_data[i]), int'(e.data));
                end
            end
        end
    end

    initial begin
        wait_cycles(5);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy_dut%0d", i), int'(busy[i]), 0);
            check($sformatf("reset_baud_en_dut%0d", i), int'(baud_en[i]), 0);
            check($sformatf("reset_rx_data_dut%0d", i), int'(rx_data[i]), 0);
            check($sformatf("reset_strobes_dut%0d", i),
                  int'({rx_valid[i], frame_err[i], parity_err[i]}), 0);
        end
        rst = 1'b0;
        wait_cycles(20);

        // Good frames
        expect_strobe(0, K_VALID, 8'h55);
        send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b1);
        wait_cycles(2 * BPS);
        expect_strobe(0, K_VALID, 8'hA3);
        send_frame(0, 8'hA3, 8, 1'b0, 1'b0, 1'b1);
        wait_cycles(BPS);
        check("good_frames_drained", exp_q.size(), 0);
        check("idle_baud_en", int'(baud_en[0]), 0);

        // False start: short low glitch
        rxd[0] = 1'b0;
        wait_cycles(50);
        check("false_start_busy", int'(busy[0]), 1);
        check("false_start_baud_en", int'(baud_en[0]), 1);
        wait_cycles(50);
        rxd[0] = 1'b1;
        wait_cycles(400);
        check("false_start_abort_busy", int'(busy[0]), 0);
        check("false_start_abort_baud_en", int'(baud_en[0]), 0);

        // Frame error, line held low two more bit times
        expect_strobe(0, K_FERR, 8'h96);
        send_frame(0, 8'h96, 8, 1'b0, 1'b0, 1'b0);
        wait_cycles(2 * BPS);
        check("break_busy", int'(busy[0]), 1);
        check("break_baud_en", int'(baud_en[0]), 0);
        rxd[0] = 1'b1;
        wait_cycles(10);
        check("break_exit_busy", int'(busy[0]), 0);
        check("frame_err_drained", exp_q.size(), 0);
        wait_cycles(BPS);

        // Reset during data bit 4 of 0xF0, then a clean 0x3C
        fork
            send_frame(0, 8'hF0, 8, 1'b0, 1'b0, 1'b1);
            begin
                wait_cycles(5 * BPS + 200);
                check("pre_reset_busy", int'(busy[0]), 1);
                rst = 1'b1;
                #1;
                check("reset_mid_baud_en", int'(baud_en[0]), 0);
                check("reset_mid_busy", int'(busy[0]), 0);
                wait_cycles(2);
                rst = 1'b0;
            end
        join
        wait_cycles(BPS);
        expect_strobe(0, K_VALID, 8'h3C);
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
        wait_cycles(BPS);
        check("reset_frame_drained", exp_q.size(), 0);

        // Even parity: bad then good parity bit on 0x07
        expect_strobe(1, K_PERR, 8'h07);
        send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1'b1);
        wait_cycles(2 * BPS);
        expect_strobe(1, K_VALID, 8'h07);
        send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1'b1);
        wait_cycles(BPS);
        check("parity_drained", exp_q.size(), 0);

        // 5-bit frames back to back, next start edge about half a bit after stop sample
        expect_strobe(2, K_VALID, 8'h1B);
        expect_strobe(2, K_VALID, 8'h1B);
        send_frame(2, 8'h1B, 5, 1'b0, 1'b0, 1'b1);
        send_frame(2, 8'h1B, 5, 1'b0, 1'b0, 1'b1);
        wait_cycles(BPS);
        check("short_frames_drained", exp_q.size(), 0);
        check("short_idle_busy", int'(busy[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side framing engine of the UART, sitting directly downstream of `baud_gen`. It synchronises the asynchronous `rxd` line, detects a start bit, and drives `baud_en` to start the baud counter. It then uses each mid-bit `baud_pulse` to sample start, data, optional parity and stop bits. Each completed byte is presented on `rx_data` with a one-cycle `rx_valid` strobe, and frame or parity errors are flagged.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8; sent LSB first.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rxd`, input, 1: raw serial line; idle is high; asynchronous to `clk`.
- `baud_pulse`, input, 1: one-cycle mid-bit sample strobe from `baud_gen`.
- `baud_en`, output, 1: enables the `baud_gen` counter; low means the counter is held at 0.
- `rx_data`, output, 8: received byte, LSB-aligned; bits above `DATA_BITS` read 0.
- `rx_valid`, output, 1: one-cycle strobe; `rx_data` holds a good frame.
- `frame_err`, output, 1: one-cycle strobe; the stop bit was sampled low.
- `parity_err`, output, 1: one-cycle strobe; the parity bit mismatched.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- **Input synchroniser:** `rxd` passes through a 2-flop synchroniser to give `rxd_s`, plus one delay flop to give `rxd_d`. All three flops reset to 1.
- **Start detect:** a start edge is `rxd_d`=1 and `rxd_s`=0 while in IDLE.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK. The state is registered.
- **`baud_en`:** equals 1 in START, DATA, PARITY and STOP; 0 in IDLE and BREAK. It is decoded from the registered state with no extra delay.
- **IDLE:** go to START on a start edge; otherwise stay.
- **START:** on `baud_pulse`, if `rxd_s`=0 go to DATA and clear the bit counter. If `rxd_s`=1 the start was false; return to IDLE and flag no error.
- **DATA:** on each `baud_pulse`, shift `rxd_s` into the MSB of a `DATA_BITS`-wide shift register (right shift, LSB first) and increment the bit counter.
  - After the `DATA_BITS`-th sample, go to PARITY if `PARITY_EN`=1, else go to STOP.
- **PARITY:** on `baud_pulse`, compute the XOR of the data bits and `rxd_s`.
  - Even parity: an error is a result of 1.
  - Odd parity: an error is a result of 0.
  - Store the error flag, then go to STOP.
- **STOP, on `baud_pulse`:**
  - `rx_data` is loaded from the shift register in every case, valid or not.
  - `rxd_s`=1 and no parity error: pulse `rx_valid`; go to IDLE.
  - `rxd_s`=1 and a stored parity error: pulse `parity_err` only (no `rx_valid`); go to IDLE.
  - `rxd_s`=0: pulse `frame_err` (no `rx_valid`, no `parity_err`); go to BREAK.
- **BREAK:** wait for `rxd_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **Idle gap:** IDLE always lasts at least one cycle with `baud_en`=0, so `baud_gen` realigns its counter for every frame.
- **`baud_pulse` outside framing states:** ignored in IDLE and BREAK.

## Timing
- **Reset values:** state = IDLE, `baud_en`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, shift register = 0, bit counter = 0.
- **Start latency:** a falling edge on `rxd` enters START 3 `clk` cycles later (2 synchroniser flops + edge flop). `baud_en` rises in the same cycle.
- **Sample alignment:** `baud_gen` produces its first pulse BPS/2+1 cycles after `baud_en` rises, then one every BPS cycles. The start sample therefore lands about BPS/2+4 cycles after the line edge, i.e. mid-bit.
- **Output latency:** `rx_valid`, `frame_err` and `parity_err` assert in the cycle after the stop-bit `baud_pulse`, each for exactly 1 cycle. `rx_data` changes in that same cycle and holds until the next stop sample.
- **Back-to-back frames:** the next start edge may arrive half a bit after the stop sample. It is detected because IDLE is entered immediately.
- **Reset mid-frame:** asynchronous return to the reset values; no strobe is emitted, and `baud_en` drops at once.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5, 3 bits;
  - bit-counter width: 3 bits;
  - `UART_MAX_BITS`=8.
- **Sub-module `sync_2ff`:** one instance; parameter RESET_VAL=1; asynchronous active-high reset.
- **Integration:** `baud_gen` is not instantiated inside this block. The top level connects `baud_en` and `baud_pulse` and inverts `rst` into `baud_gen`'s `rst_n`.

## Test plan
Bench setup: `baud_gen` with BPS=434, driven by `clk` at 50 MHz (115200 baud); 8N1 frames unless stated.
- **Good frames:** frames 0x55, then 0xA3 -> `rx_valid` pulses twice, with `rx_data`=0x55 then 0xA3; no error strobes.
- **False start:** `rxd` low glitch of 100 cycles, then high -> START is entered and then aborted to IDLE; no strobes; `baud_en` returns to 0.
- **Frame error:** stop bit forced low, line released 2 bit times later -> one `frame_err` pulse with `rx_data`=the data bits; state stays in BREAK until `rxd` goes high; no `rx_valid`.
- **Parity:** `PARITY_EN`=1, `PARITY_ODD`=0, 0x07 sent with parity bit 0 -> one `parity_err` pulse and no `rx_valid`. The same byte with parity bit 1 -> `rx_valid` with `rx_data`=0x07.
- **Reset mid-frame:** `rst` pulsed during data bit 4 of 0xF0, then a clean 0x3C frame -> no strobe for the aborted frame; `rx_data`=0x3C with `rx_valid`.
- **Short frames, minimum gap:** `DATA_BITS`=5, frame 0x1B, then a new start edge half a bit after the stop sample -> two `rx_valid` pulses, both with `rx_data`=0x1B and bits 7:5 = 0.
